// File: rtl/mips_harvard_mem_responder.sv
// Memory responder for a Harvard MIPS bus: preloads instruction/data stores from a loader stream, then serves the CPU.
// Latency: CPU reads are combinational (0 cycles); stores and loader beats commit on the next posedge.
// Backpressure: load_ready is high only in LOAD (never stalls a beat there); CPU side has no stall.
module mips_harvard_mem_responder #(
  parameter int INSTR_WORDS = 1024,
  parameter int DATA_WORDS  = 1024,
  parameter int RESET_HOLD  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_sel,
  input  logic        load_last,
  output logic        cpu_reset,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        halted,
  output logic        fault,
  output logic [15:0] load_count
);

  localparam int IW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
  localparam int DW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [31:0] IBASE = 32'hBFC0_0000;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]  state;
  logic [IW:0] iptr;
  logic [DW:0] dptr;
  logic [15:0] hold_cnt;

  logic [31:0] imem [INSTR_WORDS];
  logic [31:0] dmem [DATA_WORDS];

  logic        beat;
  logic [31:0] load_swapped;
  logic        iptr_ok;
  logic        dptr_ok;
  logic        serving;
  logic [31:0] ioff;
  logic        i_ok;
  logic        i_zero;
  logic [IW-1:0] i_idx;
  logic        d_ok;
  logic [DW-1:0] d_idx;

  assign cpu_reset    = reset | (state == S_LOAD) | (state == S_HOLD);
  assign load_ready   = !reset && (state == S_LOAD);
  assign beat         = load_valid && load_ready;
  // Instruction words arrive in MIPS big-endian order; the store keeps them byte-reversed.
  assign load_swapped = {load_data[7:0], load_data[15:8], load_data[23:16], load_data[31:24]};
  assign iptr_ok      = iptr < (IW+1)'(INSTR_WORDS);
  assign dptr_ok      = dptr < (DW+1)'(DATA_WORDS);
  assign serving      = (state == S_RUN) || (state == S_HALT);

  assign ioff   = instr_address - IBASE;
  assign i_ok   = (ioff[1:0] == 2'b00) && (ioff[31:2] < 30'(INSTR_WORDS));
  assign i_zero = (instr_address == 32'd0);
  assign i_idx  = ioff[IW+1:2];
  assign d_ok   = (data_address[1:0] == 2'b00) && (data_address[31:2] < 30'(DATA_WORDS));
  assign d_idx  = data_address[DW+1:2];

  // Zero-latency read ports; address 0 is the halt sentinel and reads as 0.
  always_comb begin
    instr_readdata = 32'd0;
    data_readdata  = 32'd0;
    if (serving && !i_zero && i_ok) instr_readdata = imem[i_idx];
    if (serving && data_read && d_ok) data_readdata = dmem[d_idx];
  end

  // Control: loader sequencing, CPU reset hold, halt detection and sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LOAD;
      iptr       <= '0;
      dptr       <= '0;
      hold_cnt   <= '0;
      load_count <= '0;
      fault      <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (beat) begin
            if (load_count != 16'hFFFF) load_count <= load_count + 16'd1;
            if (!load_sel) begin
              if (iptr_ok) iptr <= iptr + 1'b1;
              else         fault <= 1'b1;
            end else begin
              if (dptr_ok) dptr <= dptr + 1'b1;
              else         fault <= 1'b1;
            end
            if (load_last) begin
              state    <= S_HOLD;
              hold_cnt <= '0;
            end
          end
        end
        S_HOLD: begin
          if (hold_cnt == 16'(RESET_HOLD - 1)) state <= S_RUN;
          else                                 hold_cnt <= hold_cnt + 16'd1;
        end
        S_RUN: begin
          if (i_zero) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (!i_ok) begin
            fault <= 1'b1;
          end
          if ((data_read || data_write) && !d_ok) fault <= 1'b1;
        end
        default: halted <= 1'b1;
      endcase
    end
  end

  // Store write ports; contents survive reset so only the pointers rewind.
  always_ff @(posedge clk) begin
    if (beat && !load_sel && iptr_ok) imem[iptr[IW-1:0]] <= load_swapped;
  end

  // Data store is filled by the loader, then written only by CPU stores in RUN.
  always_ff @(posedge clk) begin
    if (beat && load_sel && dptr_ok)
      dmem[dptr[DW-1:0]] <= load_data;
    else if (!reset && (state == S_RUN) && data_write && d_ok)
      dmem[d_idx] <= data_writedata;
  end

endmodule
